// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: latches, masks and priority-encodes interrupt sources and
// hands the winning request to CP0 with a req/ack handshake, holding it in
// service until CP0 reports eret through irq_done.
// Register window: 0 MASK, 1 EDGE, 2 PEND (write-1-to-clear), 3 STATUS.
// Optional macro IRQC_SYNC_EN inserts a 2-flop synchroniser on irq_in.
module irq_priority_ctrl #(
    parameter int NSRC = 6,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    output logic            irq_req,
    output logic [IDW-1:0]  irq_id,
    input  logic            irq_ack,
    input  logic            irq_done,
    output logic            in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [NSRC-1:0]  mask_reg, edge_cfg, pend, irq_s, irq_q;
    logic [NSRC-1:0]  active, edge_set, w1c, ack_clr, pend_n;
    logic [IDW-1:0]   winner, irq_id_n;
    logic             irq_req_n, in_service_n;

    // Upper write-data bits beyond the source count are deliberately ignored
    logic unused_wd;
    assign unused_wd = ^wd;

`ifdef IRQC_SYNC_EN
    logic [NSRC-1:0] sync_1, sync_2;

    // Two-flop synchroniser for asynchronous interrupt lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= irq_in;
            sync_2 <= sync_1;
        end
    end

    assign irq_s = sync_2;
`else
    assign irq_s = irq_in;
`endif

    assign active   = pend & mask_reg;
    assign edge_set = irq_s & ~irq_q;
    assign w1c      = (we && addr == 2'd2) ? wd[NSRC-1:0] : '0;

    // Lowest enabled pending index wins
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) winner = IDW'(i);
        end
    end

    // Pending update: edge sources set on rise (set beats clear), level sources follow the line
    always_comb begin
        pend_n = (edge_cfg & (edge_set | (pend & ~(w1c | ack_clr)))) | (~edge_cfg & irq_s);
    end

    // Next-state and registered-output logic of the request handshake
    always_comb begin
        state_n      = state;
        irq_req_n    = irq_req;
        irq_id_n     = irq_id;
        in_service_n = in_service;
        ack_clr      = '0;
        case (state)
            IDLE: begin
                if (|active) begin
                    irq_id_n  = winner;
                    irq_req_n = 1'b1;
                    state_n   = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    irq_req_n    = 1'b0;
                    in_service_n = 1'b1;
                    ack_clr      = NSRC'(1) << irq_id;
                    state_n      = SERVICE;
                end else if (!active[irq_id]) begin
                    irq_req_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    in_service_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: begin
                irq_req_n    = 1'b0;
                in_service_n = 1'b0;
                state_n      = IDLE;
            end
        endcase
    end

    // State, handshake outputs, configuration and pending registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
            mask_reg   <= '0;
            edge_cfg   <= '0;
            pend       <= '0;
            irq_q      <= '0;
        end else begin
            state      <= state_n;
            irq_req    <= irq_req_n;
            irq_id     <= irq_id_n;
            in_service <= in_service_n;
            pend       <= pend_n;
            irq_q      <= irq_s;
            if (we && addr == 2'd0) mask_reg <= wd[NSRC-1:0];
            if (we && addr == 2'd1) edge_cfg <= wd[NSRC-1:0];
        end
    end

    // Combinational register read; STATUS packs {state, irq_id} at the LSBs
    always_comb begin
        rd = '0;
        case (addr)
            2'd0: rd[NSRC-1:0]  = mask_reg;
            2'd1: rd[NSRC-1:0]  = edge_cfg;
            2'd2: rd[NSRC-1:0]  = pend;
            2'd3: rd[IDW+1:0]   = {state, irq_id};
            default: rd = '0;
        endcase
    end

endmodule
